// File: rtl/tpu_host_sequencer_if.sv
// Host stream and TPU bus bundle for the TPU host sequencer.
// The master modport is the sequencer's view. The slave modport is the view of the host plus the TPU.
interface tpu_host_sequencer_if #(
  parameter int unsigned DATAW = 64,
  parameter int unsigned ADDRW = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  modport master (
    input  in_valid, in_data, out_ready, tpu_rdata,
    output in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_wdata
  );

  modport slave (
    output in_valid, in_data, out_ready, tpu_rdata,
    input  in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_wdata
  );

endinterface

// File: rtl/tpu_host_sequencer.sv
// Command sequencer that turns a host operand stream into TPU bus traffic.
// It loads the A and B rows, optionally clears C, starts the multiply, waits for it,
// then streams the C half-rows back to the host.
module tpu_host_sequencer #(
  parameter int unsigned DIM         = 8,
  parameter int unsigned DATAW       = 64,
  parameter int unsigned ADDRW       = 16,
  parameter int unsigned WAIT_CYCLES = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 acc_mode,
  output logic                 busy,
  output logic                 done,
  tpu_host_sequencer_if.master bus
);

  localparam int unsigned CNTW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned WAITW = $clog2(WAIT_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_CLR_C  = 3'd3;
  localparam logic [2:0] S_START  = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_READ_C = 3'd6;
  localparam logic [2:0] S_DRAIN  = 3'd7;

  localparam logic [ADDRW-1:0] A_BASE   = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE   = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE   = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] CMD_ADDR = ADDRW'(16'h0400);

  // A/B row address: base | row<<3
  function automatic logic [ADDRW-1:0] row_addr(input logic [ADDRW-1:0] base,
                                                input logic [CNTW-1:0]  row);
    return base | (ADDRW'(row) << 3);
  endfunction

  // C half-row address: base | row<<4 | half<<3
  function automatic logic [ADDRW-1:0] c_addr(input logic [CNTW-1:0] row, input logic half);
    return C_BASE | (ADDRW'(row) << 4) | (ADDRW'(half) << 3);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             half_q, half_d;
  logic [WAITW-1:0] wait_q, wait_d;
  logic             acc_q, acc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [DATAW-1:0] out_data_q, out_data_d;
  logic             r_w_q, r_w_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DATAW-1:0] wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             in_accept_c;
  logic             rd_take_c;
  logic             cnt_last_c;
  logic             wait_done_c;
  logic [CNTW-1:0]  cnt_inc_c;
  logic [WAITW-1:0] wait_inc_c;

  assign in_accept_c = bus.in_valid & in_ready_q;
  assign rd_take_c   = ~out_valid_q | bus.out_ready;
  assign cnt_last_c  = (cnt_q == CNTW'(DIM - 1));
  assign wait_done_c = (wait_q == WAITW'(WAIT_CYCLES));
  assign cnt_inc_c   = cnt_q + CNTW'(1);
  assign wait_inc_c  = wait_q + WAITW'(1);

  // State and registered-output update; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      half_q      <= 1'b0;
      wait_q      <= '0;
      acc_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      r_w_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      wait_q      <= wait_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      r_w_q       <= r_w_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-output logic; the bus defaults to idle every cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    wait_d      = wait_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    r_w_d       = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d      = acc_mode;
          cnt_d      = '0;
          half_d     = 1'b0;
          wait_d     = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_LOAD_A;
        end
      end

      S_LOAD_A: begin
        if (in_accept_c) begin
          r_w_d   = 1'b1;
          addr_d  = row_addr(A_BASE, cnt_q);
          wdata_d = bus.in_data;
          if (cnt_last_c) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end

      S_LOAD_B: begin
        if (in_accept_c) begin
          r_w_d   = 1'b1;
          addr_d  = row_addr(B_BASE, cnt_q);
          wdata_d = bus.in_data;
          if (cnt_last_c) begin
            cnt_d      = '0;
            in_ready_d = 1'b0;
            state_d    = acc_q ? S_START : S_CLR_C;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end

      S_CLR_C: begin
        r_w_d  = 1'b1;
        addr_d = c_addr(cnt_q, half_q);
        if (half_q) begin
          half_d = 1'b0;
          if (cnt_last_c) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end else begin
          half_d = 1'b1;
        end
      end

      S_START: begin
        r_w_d   = 1'b1;
        addr_d  = CMD_ADDR;
        wait_d  = '0;
        state_d = S_WAIT;
      end

      // After the last idle cycle, put the first C address on the bus so READ_C sees valid read data.
      S_WAIT: begin
        if (wait_done_c) begin
          cnt_d   = '0;
          half_d  = 1'b0;
          addr_d  = c_addr('0, 1'b0);
          state_d = S_READ_C;
        end else begin
          wait_d = wait_inc_c;
        end
      end

      // The address advances only when the output register accepts the current read.
      S_READ_C: begin
        addr_d = addr_q;
        if (rd_take_c) begin
          out_data_d  = bus.tpu_rdata;
          out_valid_d = 1'b1;
          if (half_q) begin
            half_d = 1'b0;
            if (cnt_last_c) begin
              cnt_d   = '0;
              addr_d  = '0;
              state_d = S_DRAIN;
            end else begin
              cnt_d  = cnt_inc_c;
              addr_d = c_addr(cnt_inc_c, 1'b0);
            end
          end else begin
            half_d = 1'b1;
            addr_d = c_addr(cnt_q, 1'b1);
          end
        end
      end

      S_DRAIN: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.tpu_r_w   = r_w_q;
  assign bus.tpu_addr  = addr_q;
  assign bus.tpu_wdata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
